// File: rtl/tt_response_checker.sv
// Response checker: samples a 1-output DUT after each settled input vector and compares to TRUTH.
// Optional watchdog enabled by defining TT_TIMEOUT_EN.
module tt_response_checker #(
  parameter int unsigned         N_IN    = 3,
  parameter logic [2**N_IN-1:0]  TRUTH   = 8'hE8,
  parameter int unsigned         SETTLE  = 2,
  parameter int unsigned         CNT_W   = 8,
  parameter int unsigned         TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N_IN-1:0]      vec,
  input  logic                 f,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [2**N_IN-1:0]   seen,
  output logic [N_IN-1:0]      first_err_vec,
  output logic                 first_err_valid,
  output logic                 timeout
);

  localparam int unsigned NV = 2**N_IN;
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE);

  typedef enum logic [2:0] {StIdle, StSettle, StSample, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [7:0]        settle_q, settle_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [NV-1:0]     seen_q, seen_d;
  logic [N_IN-1:0]   fev_q, fev_d;
  logic              fevld_q, fevld_d;
  logic              pass_q, pass_d;
  logic              tmo_flag;
  logic              mismatch;

`ifdef TT_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              tmo_q, tmo_d;
  assign tmo_flag = tmo_q;
`else
  assign tmo_flag = 1'b0;
`endif

  assign mismatch = (f != TRUTH[vec_q]);

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    err_d    = err_q;
    seen_d   = seen_q;
    fev_d    = fev_q;
    fevld_d  = fevld_q;
    pass_d   = pass_q;
`ifdef TT_TIMEOUT_EN
    wd_d     = wd_q;
    tmo_d    = tmo_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          err_d    = '0;
          seen_d   = '0;
          fev_d    = '0;
          fevld_d  = 1'b0;
          pass_d   = 1'b0;
          vec_d    = vec;
          settle_d = SETTLE_LD;
          state_d  = StSettle;
`ifdef TT_TIMEOUT_EN
          wd_d     = '0;
          tmo_d    = 1'b0;
`endif
        end
      end
      StSettle: begin
        // Any change restarts the window, so single-cycle glitches never get sampled.
        if (vec != vec_q) begin
          vec_d    = vec;
          settle_d = SETTLE_LD;
        end else if (settle_q == 8'd1) begin
          state_d = StSample;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      StSample: begin
        seen_d[vec_q] = 1'b1;
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          if (!fevld_q) begin
            fev_d   = vec_q;
            fevld_d = 1'b1;
          end
        end
`ifdef TT_TIMEOUT_EN
        wd_d = '0;
`endif
        state_d = (&seen_d) ? StDone : StWait;
      end
      StWait: begin
        if (vec != vec_q) begin
          vec_d    = vec;
          settle_d = SETTLE_LD;
          state_d  = StSettle;
        end
      end
      StDone: begin
        pass_d  = (err_q == '0) && !tmo_flag;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
`ifdef TT_TIMEOUT_EN
    // Watchdog overrides normal progress once the limit is hit.
    if (state_q == StSettle || state_q == StWait) begin
      if (wd_q == WD_LAST) begin
        state_d = StDone;
        tmo_d   = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      vec_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      seen_q   <= '0;
      fev_q    <= '0;
      fevld_q  <= 1'b0;
      pass_q   <= 1'b0;
`ifdef TT_TIMEOUT_EN
      wd_q     <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      seen_q   <= seen_d;
      fev_q    <= fev_d;
      fevld_q  <= fevld_d;
      pass_q   <= pass_d;
`ifdef TT_TIMEOUT_EN
      wd_q     <= wd_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign busy            = (state_q == StSettle) || (state_q == StSample) || (state_q == StWait);
  assign done            = (state_q == StDone);
  assign pass            = pass_q;
  assign err_cnt         = err_q;
  assign seen            = seen_q;
  assign first_err_vec   = fev_q;
  assign first_err_valid = fevld_q;
  assign timeout         = tmo_flag;

endmodule

// File: tb/tb_tt_response_checker.sv
// Directed, table-driven bench for tt_response_checker (3-input majority, SETTLE=2).
module tb_tt_response_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] vec = 3'd0;
  logic       f;
  logic       stuck = 1'b0;
  logic       busy, done, pass, first_err_valid, timeout;
  logic [7:0] err_cnt, seen;
  logic [2:0] first_err_vec;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;
  int exp_pulses = 0;

  always #5 clk = ~clk;

  // Reference DUT: majority, optionally stuck at 0.
  assign f = stuck ? 1'b0 : ((vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]));

  tt_response_checker #(
    .N_IN(3), .TRUTH(8'hE8), .SETTLE(2), .CNT_W(8), .TIMEOUT(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec(vec), .f(f),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .seen(seen),
    .first_err_vec(first_err_vec), .first_err_valid(first_err_valid), .timeout(timeout)
  );

  always @(negedge clk) if (done) done_pulses++;

  typedef struct {
    logic       rst;
    logic       st;
    logic       stk;
    logic [2:0] v;
    int         dwell;
    logic [7:0] seen;
    logic [7:0] err;
    logic       dn;
    logic       ps;
    logic       fvv;
    logic [2:0] fv;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(bit rst, bit st, bit stk, int v, int dw, int sn, int er,
                              bit dn, bit ps, bit fvv, int fv);
    row_t r;
    r.rst = rst; r.st = st; r.stk = stk; r.v = 3'(v); r.dwell = dw;
    r.seen = 8'(sn); r.err = 8'(er); r.dn = dn; r.ps = ps; r.fvv = fvv; r.fv = 3'(fv);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_seen", 32'(seen), 0);
    chk("rst_fev", 32'(first_err_vec), 0);
    chk("rst_fevld", 32'(first_err_valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
  endtask

  initial begin
    // R1: correct DUT, mixed dwells
    tbl.push_back(mk(0, 1, 0, 0, 7, 8'h01, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4, 8'h03, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2, 9, 8'h07, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 3, 4, 8'h0F, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4, 7, 8'h1F, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 5, 4, 8'h3F, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 6, 9, 8'h7F, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 7, 4, 8'hFF, 0, 1, 1, 0, 0));
    // R2: f stuck at 0
    tbl.push_back(mk(0, 1, 1, 0, 4, 8'h01, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 4, 8'h03, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 4, 8'h07, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3, 4, 8'h0F, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4, 4, 8'h1F, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 5, 4, 8'h3F, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 6, 4, 8'h7F, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 7, 4, 8'hFF, 4, 1, 0, 1, 3));
    // R3: short dwell on 001 is dropped; start mid-run is ignored; 001 re-applied at the end
    tbl.push_back(mk(0, 1, 0, 0, 4, 8'h01, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 2, 8'h01, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2, 4, 8'h05, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 3, 4, 8'h0D, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4, 4, 8'h1D, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 5, 4, 8'h3D, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 6, 4, 8'h7D, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 7, 4, 8'hFD, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4, 8'hFF, 0, 1, 1, 0, 0));
    // R4: glitch 100->101->100, then an error on 110; left busy
    tbl.push_back(mk(0, 1, 1, 4, 1, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 5, 1, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4, 4, 8'h10, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 6, 4, 8'h50, 1, 0, 0, 0, 0));
    // R5: reset mid-run, then a clean run
    tbl.push_back(mk(1, 1, 0, 0, 4, 8'h01, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4, 8'h03, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2, 4, 8'h07, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 3, 4, 8'h0F, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4, 4, 8'h1F, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 5, 4, 8'h3F, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 6, 4, 8'h7F, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 7, 4, 8'hFF, 0, 1, 1, 0, 0));

    repeat (2) @(negedge clk);
    chk_zero();
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        chk("busy_before_rst", 32'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_zero();
      end
      vec   = tbl[i].v;
      stuck = tbl[i].stk;
      start = tbl[i].st;
      for (int k = 0; k < tbl[i].dwell; k++) begin
        @(negedge clk);
        start = 1'b0;
      end
      chk($sformatf("seen[%0d]", i), 32'(seen), 32'(tbl[i].seen));
      chk($sformatf("err_cnt[%0d]", i), 32'(err_cnt), 32'(tbl[i].err));
      chk($sformatf("done[%0d]", i), 32'(done), 32'(tbl[i].dn));
      chk($sformatf("busy[%0d]", i), 32'(busy), 32'(!tbl[i].dn));
      if (tbl[i].dn) begin
        exp_pulses++;
        @(negedge clk);
        chk($sformatf("done_drop[%0d]", i), 32'(done), 0);
        chk($sformatf("pass[%0d]", i), 32'(pass), 32'(tbl[i].ps));
        chk($sformatf("fev_valid[%0d]", i), 32'(first_err_valid), 32'(tbl[i].fvv));
        chk($sformatf("fev[%0d]", i), 32'(first_err_vec), 32'(tbl[i].fv));
        chk($sformatf("timeout[%0d]", i), 32'(timeout), 0);
        chk($sformatf("hold_err[%0d]", i), 32'(err_cnt), 32'(tbl[i].err));
      end
    end

`ifdef TT_TIMEOUT_EN
    begin
      int n;
      vec   = 3'd0;
      stuck = 1'b0;
      start = 1'b1;
      n = 0;
      // start edge, 2 settle edges, sample edge, then 20 watchdog cycles
      while (!done && n < 100) begin
        @(negedge clk);
        start = 1'b0;
        n++;
      end
      chk("tmo_latency", 32'(n), 24);
      chk("tmo_done", 32'(done), 1);
      chk("tmo_flag", 32'(timeout), 1);
      chk("tmo_seen", 32'(seen), 32'h01);
      exp_pulses++;
      @(negedge clk);
      chk("tmo_pass", 32'(pass), 0);
      chk("tmo_busy", 32'(busy), 0);
    end
`endif

    repeat (3) @(negedge clk);
    chk("done_pulses", 32'(done_pulses), 32'(exp_pulses));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
